// File: rtl/elevator_scheduler_if.sv
// Scheduler <-> button-latch bundle: demand vectors in, car position/direction/door out.
// master = scheduler side; fireRecall exists only when FIRE_RECALL_EN is defined.
interface elevator_scheduler_if;
  logic        tick;
  logic [13:0] floorButton;
  logic [9:1]  internalButton;
  logic [2:0]  currentFloor;
  logic [1:0]  currentDirection;
  logic        doorState;
  logic        move;
  logic        enable;
`ifdef FIRE_RECALL_EN
  logic        fireRecall;

  modport master (input tick, floorButton, internalButton, fireRecall,
                  output currentFloor, currentDirection, doorState, move, enable);
  modport slave  (output tick, floorButton, internalButton, fireRecall,
                  input currentFloor, currentDirection, doorState, move, enable);
`else
  modport master (input tick, floorButton, internalButton,
                  output currentFloor, currentDirection, doorState, move, enable);
  modport slave  (output tick, floorButton, internalButton,
                  input currentFloor, currentDirection, doorState, move, enable);
`endif
endinterface

// File: rtl/elevator_scheduler.sv
// SCAN car-motion controller for 7 floors; optional fire recall via FIRE_RECALL_EN.
// Latency: state/outputs register on the tick cycle; enable is tick delayed by one cycle.
// No backpressure: demand vectors are level inputs sampled on every tick.
module elevator_scheduler #(
  parameter logic [3:0] TRAVEL_TICKS = 4'd4,
  parameter logic [3:0] DOOR_TICKS   = 4'd6
) (
  input logic           clk,
  input logic           reset,
  elevator_scheduler_if.master bus
);

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_DN   = 2'b01;

  typedef enum logic [1:0] {IDLE, DOOR_OPEN, MOVING} state_t;

  state_t     state;
  logic [2:0] floor;
  logic [1:0] dir;
  logic       door;
  logic       moving;
  logic       enable_q;
  logic [3:0] timer;
`ifdef FIRE_RECALL_EN
  logic       fire_hold;
`endif

  logic [7:1] car, hup, hdn, req;

  assign car = bus.internalButton[7:1];
  for (genvar f = 1; f <= 7; f++) begin : g_floor
    assign hup[f] = bus.floorButton[2*f-1];
    assign hdn[f] = bus.floorButton[2*f-2];
    assign req[f] = car[f] | hup[f] | hdn[f];
  end

  function automatic logic [7:1] above_mask(input logic [2:0] fl);
    return 7'h7f << fl;
  endfunction

  function automatic logic [7:1] below_mask(input logic [2:0] fl);
    return ~(7'h7f << (fl - 3'd1));
  endfunction

  logic       open_b, close_b;
  logic       here, above, below, go_up, go_dn;
  logic [1:0] idle_dir;
  logic [2:0] nf;
  logic       above_n, below_n, ahead_n, match_n, opp_n, stop_n;

  assign open_b  = bus.internalButton[9];
  assign close_b = bus.internalButton[8];

  assign here  = req[floor];
  assign above = |(req & above_mask(floor));
  assign below = |(req & below_mask(floor));
  assign idle_dir = hup[floor] ? DIR_UP : (hdn[floor] ? DIR_DN : DIR_STOP);

  // Leaving a stop: keep going the same way if there is work ahead, else reverse.
  assign go_up = above & ((dir != DIR_DN) | ~below);
  assign go_dn = below & ~go_up;

  // Stop test is evaluated against the floor the car is about to arrive at.
  assign nf = (dir == DIR_UP) ? ((floor == 3'd7) ? 3'd7 : floor + 3'd1)
                              : ((floor == 3'd1) ? 3'd1 : floor - 3'd1);
  assign above_n = |(req & above_mask(nf));
  assign below_n = |(req & below_mask(nf));
  assign ahead_n = (dir == DIR_UP) ? above_n : below_n;
  assign match_n = (dir == DIR_UP) ? hup[nf] : hdn[nf];
  assign opp_n   = (dir == DIR_UP) ? hdn[nf] : hup[nf];
  assign stop_n  = car[nf] | match_n | ~ahead_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      floor    <= 3'd1;
      dir      <= DIR_STOP;
      door     <= 1'b0;
      moving   <= 1'b0;
      enable_q <= 1'b0;
      timer    <= 4'd0;
`ifdef FIRE_RECALL_EN
      fire_hold <= 1'b0;
`endif
    end else begin
      enable_q <= bus.tick;
      if (bus.tick) begin
`ifdef FIRE_RECALL_EN
        if (bus.fireRecall) begin
          if (state == MOVING) begin
            if (timer > 4'd1) begin
              timer <= timer - 4'd1;
            end else begin
              floor <= nf;
              if (nf == 3'd1) begin
                state     <= DOOR_OPEN;
                moving    <= 1'b0;
                door      <= 1'b1;
                dir       <= DIR_STOP;
                fire_hold <= 1'b1;
              end else begin
                dir   <= DIR_DN;
                timer <= TRAVEL_TICKS;
              end
            end
          end else if (floor == 3'd1) begin
            // Parked at the lobby with the door held; the door timer stays frozen.
            state     <= DOOR_OPEN;
            door      <= 1'b1;
            moving    <= 1'b0;
            dir       <= DIR_STOP;
            fire_hold <= 1'b1;
          end else begin
            state  <= MOVING;
            door   <= 1'b0;
            moving <= 1'b1;
            dir    <= DIR_DN;
            timer  <= TRAVEL_TICKS;
          end
        end else if (fire_hold) begin
          timer     <= DOOR_TICKS;
          fire_hold <= 1'b0;
        end else
`endif
        begin
          case (state)
            IDLE: begin
              if (here || open_b) begin
                state <= DOOR_OPEN;
                door  <= 1'b1;
                dir   <= idle_dir;
                timer <= DOOR_TICKS;
              end else if (above || below) begin
                state  <= MOVING;
                moving <= 1'b1;
                dir    <= above ? DIR_UP : DIR_DN;
                timer  <= TRAVEL_TICKS;
              end
            end
            DOOR_OPEN: begin
              if (open_b) begin
                timer <= DOOR_TICKS;
              end else if (close_b || timer <= 4'd1) begin
                door <= 1'b0;
                if (go_up || go_dn) begin
                  state  <= MOVING;
                  moving <= 1'b1;
                  dir    <= go_up ? DIR_UP : DIR_DN;
                  timer  <= TRAVEL_TICKS;
                end else begin
                  state <= IDLE;
                  dir   <= DIR_STOP;
                  timer <= 4'd0;
                end
              end else begin
                timer <= timer - 4'd1;
              end
            end
            MOVING: begin
              if (timer > 4'd1) begin
                timer <= timer - 4'd1;
              end else begin
                floor <= nf;
                if (stop_n) begin
                  state  <= DOOR_OPEN;
                  moving <= 1'b0;
                  door   <= 1'b1;
                  timer  <= DOOR_TICKS;
                  if (!ahead_n && !match_n && opp_n)
                    dir <= (dir == DIR_UP) ? DIR_DN : DIR_UP;
                end else begin
                  timer <= TRAVEL_TICKS;
                end
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.currentFloor     = floor;
  assign bus.currentDirection = dir;
  assign bus.doorState        = door;
  assign bus.move             = moving;
  assign bus.enable           = enable_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler; obs packs {floor, dir, door, move}.
module tb_elevator_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  elevator_scheduler_if bus();

  elevator_scheduler #(.TRAVEL_TICKS(4'd4), .DOOR_TICKS(4'd6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] obs;
  assign obs = {bus.currentFloor, bus.currentDirection, bus.doorState, bus.move};

  task automatic do_tick();
    @(negedge clk); bus.tick = 1'b1;
    @(posedge clk); #1; bus.tick = 1'b0;
  endtask

  task automatic idle_cyc();
    @(negedge clk); bus.tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic hard_reset();
    @(negedge clk); reset = 1'b1;
    bus.floorButton = '0; bus.internalButton = '0;
    idle_cyc(); idle_cyc();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    hard_reset();
    checks++; if (obs !== {3'd1, 2'b00, 1'b0, 1'b0}) begin failures++; $display("FAIL reset_state got=%b exp=%b", obs, {3'd1, 2'b00, 1'b0, 1'b0}); end
    checks++; if (bus.enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", bus.enable); end
    do_tick();
    checks++; if (obs !== {3'd1, 2'b00, 1'b0, 1'b0}) begin failures++; $display("FAIL idle_no_demand got=%b exp=%b", obs, {3'd1, 2'b00, 1'b0, 1'b0}); end
    checks++; if (bus.enable !== 1'b1) begin failures++; $display("FAIL enable_after_tick got=%b exp=1", bus.enable); end
    idle_cyc();
    checks++; if (bus.enable !== 1'b0) begin failures++; $display("FAIL enable_no_tick got=%b exp=0", bus.enable); end
  endtask

  task automatic test_travel();
    bus.internalButton[5] = 1'b1;
    do_tick();
    checks++; if (obs !== {3'd1, 2'b10, 1'b0, 1'b1}) begin failures++; $display("FAIL travel_start got=%b exp=%b", obs, {3'd1, 2'b10, 1'b0, 1'b1}); end
    ticks(15);
    checks++; if (obs !== {3'd4, 2'b10, 1'b0, 1'b1}) begin failures++; $display("FAIL travel_15 got=%b exp=%b", obs, {3'd4, 2'b10, 1'b0, 1'b1}); end
    do_tick();
    checks++; if (obs !== {3'd5, 2'b10, 1'b1, 1'b0}) begin failures++; $display("FAIL travel_arrive got=%b exp=%b", obs, {3'd5, 2'b10, 1'b1, 1'b0}); end
    bus.internalButton[5] = 1'b0;
    ticks(5);
    checks++; if (bus.doorState !== 1'b1) begin failures++; $display("FAIL door_5_ticks got=%b exp=1", bus.doorState); end
    do_tick();
    checks++; if (obs !== {3'd5, 2'b00, 1'b0, 1'b0}) begin failures++; $display("FAIL travel_idle got=%b exp=%b", obs, {3'd5, 2'b00, 1'b0, 1'b0}); end
  endtask

  task automatic test_scan();
    hard_reset();
    bus.floorButton[4] = 1'b1;
    bus.internalButton[6] = 1'b1;
    do_tick();
    // Tick only every other cycle: timers must ignore non-tick cycles.
    for (int i = 0; i < 19; i++) begin do_tick(); idle_cyc(); end
    checks++; if (obs !== {3'd5, 2'b10, 1'b0, 1'b1}) begin failures++; $display("FAIL scan_pass3 got=%b exp=%b", obs, {3'd5, 2'b10, 1'b0, 1'b1}); end
    do_tick();
    checks++; if (obs !== {3'd6, 2'b10, 1'b1, 1'b0}) begin failures++; $display("FAIL scan_stop6 got=%b exp=%b", obs, {3'd6, 2'b10, 1'b1, 1'b0}); end
    bus.internalButton[6] = 1'b0;
    ticks(6);
    checks++; if (obs !== {3'd6, 2'b01, 1'b0, 1'b1}) begin failures++; $display("FAIL scan_reverse got=%b exp=%b", obs, {3'd6, 2'b01, 1'b0, 1'b1}); end
    bus.internalButton[9] = 1'b1;
    ticks(6);
    bus.internalButton[9] = 1'b0;
    ticks(6);
    checks++; if (obs !== {3'd3, 2'b01, 1'b1, 1'b0}) begin failures++; $display("FAIL scan_stop3 got=%b exp=%b", obs, {3'd3, 2'b01, 1'b1, 1'b0}); end
    bus.floorButton[4] = 1'b0;
    ticks(6);
    checks++; if (obs !== {3'd3, 2'b00, 1'b0, 1'b0}) begin failures++; $display("FAIL scan_idle3 got=%b exp=%b", obs, {3'd3, 2'b00, 1'b0, 1'b0}); end
    bus.internalButton[1] = 1'b1;
    bus.internalButton[5] = 1'b1;
    do_tick();
    checks++; if (obs !== {3'd3, 2'b10, 1'b0, 1'b1}) begin failures++; $display("FAIL above_priority got=%b exp=%b", obs, {3'd3, 2'b10, 1'b0, 1'b1}); end
    ticks(8);
    checks++; if (obs !== {3'd5, 2'b10, 1'b1, 1'b0}) begin failures++; $display("FAIL prio_stop5 got=%b exp=%b", obs, {3'd5, 2'b10, 1'b1, 1'b0}); end
    bus.internalButton[5] = 1'b0;
    ticks(6);
    checks++; if (obs !== {3'd5, 2'b01, 1'b0, 1'b1}) begin failures++; $display("FAIL prio_reverse got=%b exp=%b", obs, {3'd5, 2'b01, 1'b0, 1'b1}); end
    ticks(16);
    checks++; if (obs !== {3'd1, 2'b01, 1'b1, 1'b0}) begin failures++; $display("FAIL prio_stop1 got=%b exp=%b", obs, {3'd1, 2'b01, 1'b1, 1'b0}); end
    bus.internalButton[1] = 1'b0;
    ticks(6);
    checks++; if (obs !== {3'd1, 2'b00, 1'b0, 1'b0}) begin failures++; $display("FAIL prio_idle1 got=%b exp=%b", obs, {3'd1, 2'b00, 1'b0, 1'b0}); end
  endtask

  task automatic test_idle_choice();
    bus.floorButton[1] = 1'b1;
    bus.internalButton[3] = 1'b1;
    do_tick();
    checks++; if (obs !== {3'd1, 2'b10, 1'b1, 1'b0}) begin failures++; $display("FAIL here_first got=%b exp=%b", obs, {3'd1, 2'b10, 1'b1, 1'b0}); end
    bus.floorButton[1] = 1'b0;
    ticks(6);
    checks++; if (obs !== {3'd1, 2'b10, 1'b0, 1'b1}) begin failures++; $display("FAIL door_to_move got=%b exp=%b", obs, {3'd1, 2'b10, 1'b0, 1'b1}); end
    ticks(8);
    checks++; if (obs !== {3'd3, 2'b10, 1'b1, 1'b0}) begin failures++; $display("FAIL car_stop3 got=%b exp=%b", obs, {3'd3, 2'b10, 1'b1, 1'b0}); end
    bus.internalButton[3] = 1'b0;
    ticks(6);
    bus.floorButton[4] = 1'b1;
    do_tick();
    checks++; if (obs !== {3'd3, 2'b01, 1'b1, 1'b0}) begin failures++; $display("FAIL here_down got=%b exp=%b", obs, {3'd3, 2'b01, 1'b1, 1'b0}); end
    bus.floorButton[4] = 1'b0;
    ticks(6);
    checks++; if (obs !== {3'd3, 2'b00, 1'b0, 1'b0}) begin failures++; $display("FAIL here_down_idle got=%b exp=%b", obs, {3'd3, 2'b00, 1'b0, 1'b0}); end
  endtask

  task automatic test_top_end();
    hard_reset();
    bus.floorButton[12] = 1'b1;
    ticks(25);
    checks++; if (obs !== {3'd7, 2'b01, 1'b1, 1'b0}) begin failures++; $display("FAIL top_stop got=%b exp=%b", obs, {3'd7, 2'b01, 1'b1, 1'b0}); end
    bus.floorButton[12] = 1'b0;
    ticks(12);
    checks++; if (obs !== {3'd7, 2'b00, 1'b0, 1'b0}) begin failures++; $display("FAIL top_idle got=%b exp=%b", obs, {3'd7, 2'b00, 1'b0, 1'b0}); end
  endtask

  task automatic test_door_hold();
    int bad;
    bad = 0;
    bus.internalButton[9] = 1'b1;
    do_tick();
    checks++; if (obs !== {3'd7, 2'b00, 1'b1, 1'b0}) begin failures++; $display("FAIL open_from_idle got=%b exp=%b", obs, {3'd7, 2'b00, 1'b1, 1'b0}); end
    for (int i = 0; i < 10; i++) begin
      do_tick();
      if (bus.doorState !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL open_hold closed_ticks=%0d exp=0", bad); end
    bus.internalButton[9] = 1'b0;
    bus.internalButton[8] = 1'b1;
    do_tick();
    checks++; if (obs !== {3'd7, 2'b00, 1'b0, 1'b0}) begin failures++; $display("FAIL close_now got=%b exp=%b", obs, {3'd7, 2'b00, 1'b0, 1'b0}); end
    bus.internalButton[8] = 1'b0;
  endtask

  task automatic test_reset_midmove();
    bus.internalButton[1] = 1'b1;
    ticks(15);
    checks++; if (obs !== {3'd4, 2'b01, 1'b0, 1'b1}) begin failures++; $display("FAIL midmove_pos got=%b exp=%b", obs, {3'd4, 2'b01, 1'b0, 1'b1}); end
    #2 reset = 1'b1;
    #1;
    checks++; if (obs !== {3'd1, 2'b00, 1'b0, 1'b0}) begin failures++; $display("FAIL async_reset got=%b exp=%b", obs, {3'd1, 2'b00, 1'b0, 1'b0}); end
    bus.internalButton[1] = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (obs !== {3'd1, 2'b00, 1'b0, 1'b0}) begin failures++; $display("FAIL reset_release got=%b exp=%b", obs, {3'd1, 2'b00, 1'b0, 1'b0}); end
  endtask

`ifdef FIRE_RECALL_EN
  task automatic test_fire_recall();
    hard_reset();
    bus.internalButton[6] = 1'b1;
    ticks(17);
    checks++; if (obs !== {3'd5, 2'b10, 1'b0, 1'b1}) begin failures++; $display("FAIL fire_pre got=%b exp=%b", obs, {3'd5, 2'b10, 1'b0, 1'b1}); end
    bus.fireRecall = 1'b1;
    ticks(4);
    checks++; if (obs !== {3'd6, 2'b01, 1'b0, 1'b1}) begin failures++; $display("FAIL fire_reverse got=%b exp=%b", obs, {3'd6, 2'b01, 1'b0, 1'b1}); end
    ticks(20);
    checks++; if (obs !== {3'd1, 2'b00, 1'b1, 1'b0}) begin failures++; $display("FAIL fire_lobby got=%b exp=%b", obs, {3'd1, 2'b00, 1'b1, 1'b0}); end
    ticks(10);
    checks++; if (obs !== {3'd1, 2'b00, 1'b1, 1'b0}) begin failures++; $display("FAIL fire_hold got=%b exp=%b", obs, {3'd1, 2'b00, 1'b1, 1'b0}); end
    bus.fireRecall = 1'b0;
    ticks(6);
    checks++; if (bus.doorState !== 1'b1) begin failures++; $display("FAIL fire_release_door got=%b exp=1", bus.doorState); end
    do_tick();
    checks++; if (obs !== {3'd1, 2'b10, 1'b0, 1'b1}) begin failures++; $display("FAIL fire_resume got=%b exp=%b", obs, {3'd1, 2'b10, 1'b0, 1'b1}); end
    bus.internalButton[6] = 1'b0;
  endtask
`endif

  initial begin
    bus.tick = 1'b0;
    bus.floorButton = '0;
    bus.internalButton = '0;
`ifdef FIRE_RECALL_EN
    bus.fireRecall = 1'b0;
`endif
    test_reset();
    test_travel();
    test_scan();
    test_idle_choice();
    test_top_end();
    test_door_hold();
    test_reset_midmove();
`ifdef FIRE_RECALL_EN
    test_fire_recall();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
